mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported instruction/data memory between the fetch stage and the MEM stage of the 5-stage pipeline core. Data accesses take priority over fetch, with a bounded-streak fairness rule so fetch is never starved. One transaction is in flight at a time. A stall output freezes the pipeline while either requester waits.

## Interface
- `MAX_D_STREAK`, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win (≥1).
- `TIMEOUT`, 255: watchdog limit in cycles; used only when the watchdog is compiled in.
- `clk` input 1: the block's single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch read request; held with `if_addr` until `if_gnt`.
- `if_addr` input 32: fetch address.
- `if_gnt` output 1: fetch request accepted by memory.
- `if_rvalid` output 1: fetch read data valid.
- `d_req` input 1: data request; held with `d_we`, `d_addr`, `d_wdata` until `d_gnt`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input 32: data address.
- `d_wdata` input 32: write data.
- `d_gnt` output 1: data request accepted.
- `d_rvalid` output 1: data read data valid.
- `rdata` output 32: `mem_rdata` passed through to both requesters.
- `mem_req` output 1: request to memory (registered).
- `mem_we`, `mem_addr`, `mem_wdata` output 1/32/32: registered request fields.
- `mem_ready` input 1: memory accepts `mem_req` this cycle.
- `mem_rvalid` input 1: memory read data valid.
- `mem_rdata` input 32: memory read data.
- `err` output 1: completion pulse was a watchdog abort.
- `stall` output 1: pipeline freeze.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if any request is present, select an owner and latch its fields into the `mem_*` registers. Set `mem_req`=1 and go to REQ.
- Selection:
  - Data wins by default.
  - If `if_req` is high and the streak counter equals `MAX_D_STREAK`, fetch wins.
  - The streak counter increments when data wins while `if_req`=1.
  - The counter clears when fetch wins, and also whenever `if_req`=0 in IDLE.
  - The counter saturates; it never wraps.
- REQ: the owner's `*_gnt` is driven combinationally as REQ & owner & `mem_ready`. On acceptance, `mem_req` clears.
  - Write: next state is IDLE; the write completes at `gnt`.
  - Read: next state is RESP.
- RESP: the owner's `*_rvalid` is driven as RESP & owner & `mem_rvalid`, with `rdata`=`mem_rdata`. On `mem_rvalid` the FSM returns to IDLE.
- `mem_rvalid` is ignored in IDLE and REQ.
- A requester must not reassert `req` for a new transaction until the cycle after its `gnt`. For reads it must also wait until after its `rvalid`.
- `stall` = (state≠IDLE or `if_req` or `d_req`) and not completing this cycle. Completion means `gnt` for a write, or `rvalid` for a read.
- `rst_n` low at any time:
  - FSM goes to IDLE; `mem_req`, `mem_we` and the streak counter go to 0; `mem_addr` and `mem_wdata` go to 0.
  - An in-flight transaction is dropped, and a late `mem_rvalid` is ignored.

## Timing
- Reset values: `mem_*`=0. All combinational outputs (`if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `err`) are 0 in IDLE. `stall`=0 with no request.
- Request sampled in IDLE at cycle N: `mem_req`=1 from N+1.
- With `mem_ready`=1 at N+1: `gnt` at N+1.
- Earliest read data: `mem_rvalid` at N+2, giving `rvalid` at N+2.
- Minimum transaction time: 2 cycles for a write, 3 cycles for a read.
- Simultaneous `if_req` and `d_req` in IDLE: exactly one wins. The loser keeps `stall` high and is served in the next IDLE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: a cycle counter runs in REQ and RESP and clears on state entry.
  - At `TIMEOUT` cycles in REQ: drop `mem_req`, pulse the owner's `gnt` with `err`=1, go to IDLE.
  - At `TIMEOUT` cycles in RESP: pulse the owner's `rvalid` with `rdata`=0 and `err`=1, go to IDLE.
- Not defined: no counter; `err` is tied to 0; the arbiter waits indefinitely.

## Structure
- Package `mem_arb_pkg`: FSM state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2) and owner encoding (OWN_IF=1'b0, OWN_D=1'b1).
- Sub-module `arb_fair_sel`: priority selection plus the streak counter. Inputs: `if_req`, `d_req`, sample strobe. Output: winner.

## Test plan
- Lone fetch read, `mem_ready`=1, `mem_rvalid` at the next cycle → `if_gnt` at N+1, `if_rvalid` at N+2, `rdata`=`mem_rdata`, `stall` high for N..N+1.
- Simultaneous `d_req` write (addr 0x100, data 0xDEADBEEF) and `if_req` → data first, `mem_we`=1 with the correct fields, `d_gnt` at N+1; fetch issued from N+2.
- `d_req` held continuously with `if_req` pending, `MAX_D_STREAK`=4 → 4 data grants, then 1 fetch grant; the pattern repeats.
- `mem_ready` low for 5 cycles → `mem_req` and fields stable; `stall` high; `gnt` exactly on the cycle `mem_ready` rises.
- `rst_n` asserted in RESP, then `mem_rvalid` pulsed after release → no `rvalid`, FSM in IDLE, `mem_req`=0.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=8, no `mem_rvalid` → `rvalid`+`err` 8 cycles after RESP entry, `rdata`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_arb_pkg                                                                |
// | Shared state and owner encodings for the memory port arbiter.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_fair_sel.sv
// +----------------------------------------------------------------------------+
// | arb_fair_sel                                                               |
// | Data-first requester selection with a bounded data-streak counter.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_fair_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       sample,
    input  logic       idle,
    output arb_owner_t winner
);

    localparam int                 c_CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_D_STREAK);

    logic [c_CNT_W-1:0] r_streak;

    // Fetch wins when alone, or when data has used up its streak allowance.
    always_comb begin
        winner = OWN_D;
        if (if_req && (!d_req || (r_streak == c_MAX))) begin
            winner = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (idle && !if_req) begin
            r_streak <= '0;
        end else if (sample) begin
            if (winner == OWN_IF) begin
                r_streak <= '0;
            end else if (r_streak != c_MAX) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one memory port between fetch and data; one transaction in flight.  |
// | Optional watchdog: define MEM_ARB_TIMEOUT_EN.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic        stall
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    arb_owner_t r_owner;
    arb_owner_t w_winner;
    logic       w_idle;
    logic       w_sample;
    logic       w_accept;
    logic       w_resp_done;
    logic       w_complete;
    logic       w_wd_hit;

    assign w_idle   = (r_state == IDLE);
    assign w_sample = w_idle && (if_req || d_req);

    arb_fair_sel #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .sample (w_sample),
        .idle   (w_idle),
        .winner (w_winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_TIMEOUT = c_WD_W'(TIMEOUT);

    logic [c_WD_W-1:0] r_wd_cnt;

    // Restart on every state change so REQ and RESP each get a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (w_idle || (w_state_nxt != r_state)) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_TIMEOUT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_hit = !w_idle && (r_wd_cnt == c_TIMEOUT);
`else
    // Watchdog compiled out; the comparison only keeps TIMEOUT referenced.
    assign w_wd_hit = (TIMEOUT < 0);
`endif

    assign w_accept    = (r_state == REQ)  && (mem_ready  || w_wd_hit);
    assign w_resp_done = (r_state == RESP) && (mem_rvalid || w_wd_hit);
    assign w_complete  = (w_accept && (mem_we || w_wd_hit)) || w_resp_done;

    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        err         = w_wd_hit;
        rdata       = mem_rdata;
        stall       = (!w_idle || if_req || d_req) && !w_complete;
        unique case (r_state)
            IDLE: begin
                if (w_sample) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if_gnt = w_accept && (r_owner == OWN_IF);
                d_gnt  = w_accept && (r_owner == OWN_D);
                if (w_wd_hit) begin
                    w_state_nxt = IDLE;
                end else if (mem_ready) begin
                    w_state_nxt = mem_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if_rvalid = w_resp_done && (r_owner == OWN_IF);
                d_rvalid  = w_resp_done && (r_owner == OWN_D);
                if (w_wd_hit) begin
                    rdata = '0;
                end
                if (w_resp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sample) begin
                r_owner <= w_winner;
                mem_req <= 1'b1;
                if (w_winner == OWN_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
            end else if (w_accept) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed bench with a transaction-level reference model for the arbiter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

    localparam int c_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err, stall;

    int checks = 0;
    int failures = 0;

    bit          auto_rsp = 1'b1;
    bit          force_rvalid = 1'b0;
    bit          chk_en = 1'b1;
    logic [31:0] bg_rdata = 32'h1357_9BDF;
    logic        rsp_pend = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] rsp_data = '0;
    string       glog = "";

    mem_port_arbiter #(
        .MAX_D_STREAK (c_MAX),
        .TIMEOUT      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Memory: answers an accepted read one cycle later with addr ^ 0x5A5A0000.
    assign mem_rvalid = rsp_valid | force_rvalid;
    assign mem_rdata  = rsp_valid ? rsp_data : bg_rdata;

    always @(negedge clk) begin
        rsp_pend = auto_rsp && mem_req && mem_ready && !mem_we;
        rsp_addr = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        rsp_valid = rsp_pend;
        rsp_data  = rsp_addr ^ 32'h5A5A_0000;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding request record plus a streak count.
    bit          m_busy = 0, m_own_d = 0, m_we = 0, m_acc = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    int          m_streak = 0;
    bit          acc_now, rv_now, done_now, fetch_wins;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_own_d = 0; m_we = 0; m_acc = 0;
            m_addr = '0; m_wdata = '0; m_streak = 0;
        end
        acc_now  = m_busy && !m_acc && mem_ready;
        rv_now   = m_busy && m_acc && mem_rvalid;
        done_now = (acc_now && m_we) || rv_now;
        if (chk_en) begin
            chk("m_if_gnt",    {31'd0, if_gnt},    {31'd0, acc_now && !m_own_d});
            chk("m_d_gnt",     {31'd0, d_gnt},     {31'd0, acc_now && m_own_d});
            chk("m_if_rvalid", {31'd0, if_rvalid}, {31'd0, rv_now && !m_own_d});
            chk("m_d_rvalid",  {31'd0, d_rvalid},  {31'd0, rv_now && m_own_d});
            chk("m_rdata",     rdata,              mem_rdata);
            chk("m_mem_req",   {31'd0, mem_req},   {31'd0, m_busy && !m_acc});
            chk("m_mem_we",    {31'd0, mem_we},    {31'd0, m_we});
            chk("m_mem_addr",  mem_addr,           m_addr);
            chk("m_mem_wdata", mem_wdata,          m_wdata);
            chk("m_err",       {31'd0, err},       32'd0);
            chk("m_stall",     {31'd0, stall},     {31'd0, (m_busy || if_req || d_req) && !done_now});
        end
        if (if_gnt) glog = {glog, "I"};
        if (d_gnt)  glog = {glog, "D"};
        if (rst_n) begin
            if (!m_busy) begin
                if (if_req || d_req) begin
                    fetch_wins = if_req && (!d_req || m_streak >= c_MAX);
                    if (fetch_wins || !if_req) m_streak = 0;
                    else if (m_streak < c_MAX) m_streak = m_streak + 1;
                    m_busy  = 1;
                    m_acc   = 0;
                    m_own_d = !fetch_wins;
                    m_we    = fetch_wins ? 1'b0 : d_we;
                    m_addr  = fetch_wins ? if_addr : d_addr;
                    m_wdata = fetch_wins ? 32'd0 : d_wdata;
                end else begin
                    m_streak = 0;
                end
            end else if (acc_now) begin
                if (m_we) m_busy = 0;
                else m_acc = 1;
            end else if (rv_now) begin
                m_busy = 0;
            end
        end
    end

    task automatic wait_hi(input int sel, input string name);
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = if_gnt;
                1:       seen = d_gnt;
                2:       seen = if_rvalid;
                default: seen = d_rvalid;
            endcase
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s wait expired t=%0t", name, $time);
        end
    endtask

    task automatic d_write(input logic [31:0] a, input logic [31:0] wd, input bit keep);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd;
        wait_hi(1, "d_write_gnt");
        @(posedge clk); #1;
        if (!keep) d_req = 1'b0;
    endtask

    task automatic if_read(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
        wait_hi(0, "if_read_gnt");
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_hi(2, "if_read_rvalid");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr",  mem_addr,         32'd0);
        chk("rst_mem_wdata", mem_wdata,        32'd0);
        chk("rst_stall",     {31'd0, stall},   32'd0);
        @(posedge clk); #1;

        // Lone fetch read
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        chk("t1_stall_n0", {31'd0, stall},  32'd1);
        chk("t1_gnt_n0",   {31'd0, if_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_if_gnt",   {31'd0, if_gnt},  32'd1);
        chk("t1_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("t1_mem_addr", mem_addr,         32'h0000_0040);
        chk("t1_stall_n1", {31'd0, stall},   32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1_rdata",     rdata,              32'h5A5A_0040);
        chk("t1_stall_n2",  {31'd0, stall},     32'd0);
        @(posedge clk); #1;

        // Simultaneous data write and fetch: data first
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        @(negedge clk);
        chk("t2_stall_n0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_d_gnt",     {31'd0, d_gnt},  32'd1);
        chk("t2_if_gnt",    {31'd0, if_gnt}, 32'd0);
        chk("t2_mem_we",    {31'd0, mem_we}, 32'd1);
        chk("t2_mem_addr",  mem_addr,        32'h0000_0100);
        chk("t2_mem_wdata", mem_wdata,       32'hDEAD_BEEF);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_mem_req_n2", {31'd0, mem_req}, 32'd0);
        chk("t2_stall_n2",   {31'd0, stall},   32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_if_gnt_n3",   {31'd0, if_gnt}, 32'd1);
        chk("t2_mem_addr_n3", mem_addr,        32'h0000_0080);
        chk("t2_mem_we_n3",   {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        @(posedge clk); #1;

        // Continuous data writes with fetch pending: 4 data grants, then fetch
        glog = "";
        fork
            begin
                for (int i = 0; i < 8; i++)
                    d_write(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), i < 7);
            end
            begin
                for (int j = 0; j < 2; j++)
                    if_read(32'h2000 + 32'(j * 4));
            end
        join
        checks++;
        if (glog != "DDDDIDDDDI") begin
            failures++;
            $display("FAIL t3_grant_order got=%s exp=DDDDIDDDDI", glog);
        end
        repeat (2) @(posedge clk);
        #1;

        // Memory not ready for 5 cycles
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h1234_5678;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t4_mem_req",  {31'd0, mem_req}, 32'd1);
            chk("t4_mem_addr", mem_addr,         32'h0000_0200);
            chk("t4_d_gnt",    {31'd0, d_gnt},   32'd0);
            chk("t4_stall",    {31'd0, stall},   32'd1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t4_d_gnt_rise", {31'd0, d_gnt}, 32'd1);
        chk("t4_stall_done", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0;

        // Reset while waiting for read data, then a late mem_rvalid
        auto_rsp = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        wait_hi(1, "t5_d_gnt");
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("t5_stall_resp", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_mem_req_rst", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        force_rvalid = 1'b1;
        @(negedge clk);
        chk("t5_no_rvalid",  {31'd0, d_rvalid}, 32'd0);
        chk("t5_mem_req",    {31'd0, mem_req},  32'd0);
        chk("t5_stall_idle", {31'd0, stall},    32'd0);
        @(posedge clk); #1;
        force_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_idle_stall2", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
        // Read with no response: watchdog aborts 8 cycles after RESP entry
        chk_en = 1'b0;
        bg_rdata = 32'hFFFF_FFFF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        wait_hi(1, "t6_d_gnt");
        @(posedge clk); #1;
        d_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_no_rvalid_early", {31'd0, d_rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_wd_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t6_wd_err",    {31'd0, err},      32'd1);
        chk("t6_wd_rdata",  rdata,             32'd0);
        @(posedge clk); #1;
`endif
        auto_rsp = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
